// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw pushbutton inputs and the conditioned direction levels and press strobes.
// master drives btn_in (board / testbench); slave is the conditioner.
interface button_conditioner_if;
  logic [3:0] btn_in;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [3:0] btn_pulse;

  modport master (output btn_in, input up, down, left, right, btn_pulse);
  modport slave  (input btn_in, output up, down, left, right, btn_pulse);
endinterface

// File: rtl/button_conditioner.sv
// Four-button synchronizer + debounce FSM producing clean direction levels and press strobes.
// Optional macro BTN_AUTOREPEAT_EN adds per-button auto-repeat on btn_pulse.
module button_conditioner_lane #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic          sync1, s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          press_acc;
  logic          rpt_hit;

  assign cnt_done  = (cnt == CW'(DEB_CYCLES));
  assign press_acc = (state == PRESS_WAIT) && s && cnt_done;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt, rnext, rlimit;
  logic          rep;   // first repeat already issued; later ones use the period

  assign rnext   = rcnt + 1'b1;
  assign rlimit  = rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
  assign rpt_hit = ((state == HELD) || (state == RELEASE_WAIT)) && (rnext == rlimit);

  // Cleared only on a fresh acceptance, so a release-bounce back to HELD keeps cadence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (press_acc) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if ((state == HELD) || (state == RELEASE_WAIT)) begin
      if (rpt_hit) begin
        rcnt <= '0;
        rep  <= 1'b1;
      end else begin
        rcnt <= rnext;
      end
    end else begin
      rcnt <= '0;
      rep  <= 1'b0;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      pulse <= press_acc | rpt_hit;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end
        end
        default: begin // RELEASE_WAIT
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

module button_conditioner #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  btn
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] lvl;
  logic [NUM_LANES-1:0] pls;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    button_conditioner_lane #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn.btn_in[i]),
      .level(lvl[i]),
      .pulse(pls[i])
    );
  end

  assign btn.up        = lvl[3];
  assign btn.down      = lvl[2];
  assign btn.left      = lvl[1];
  assign btn.right     = lvl[0];
  assign btn.btn_pulse = pls;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DEB_CYCLES=4: vector table plus reset / hold sequences.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_conditioner_if bus();

  button_conditioner #(.DEB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
    .clk(clk),
    .rst(rst),
    .btn(bus)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] pls;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] levels();
    return {bus.up, bus.down, bus.left, bus.right};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p);
    vec_t v;
    v.btn = b; v.lvl = l; v.pls = p;
    tbl.push_back(v);
  endtask

  // Drive btn before an edge, sample 1 time unit after it
  task automatic step(input logic [3:0] b);
    bus.btn_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // up press: accepted after edge 6, strobe only that cycle; then release
    for (int i = 0; i < 8; i++) add(4'b1000, (i >= 6) ? 4'b1000 : 4'b0000, (i == 6) ? 4'b1000 : 4'b0000);
    for (int i = 0; i < 7; i++) add(4'b0000, (i >= 6) ? 4'b0000 : 4'b1000, 4'b0000);
    for (int i = 0; i < 2; i++) add(4'b0000, 4'b0000, 4'b0000);
    // left short bounce (3 cycles) is rejected
    for (int i = 0; i < 3; i++) add(4'b0010, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) add(4'b0000, 4'b0000, 4'b0000);
    // 4-cycle bounce is still one sample short of acceptance
    for (int i = 0; i < 4; i++) add(4'b0010, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) add(4'b0000, 4'b0000, 4'b0000);
    // right held, 2-cycle dropout, restored: no release, no second strobe
    for (int i = 0; i < 8; i++) add(4'b0001, (i >= 6) ? 4'b0001 : 4'b0000, (i == 6) ? 4'b0001 : 4'b0000);
    for (int i = 0; i < 2; i++) add(4'b0000, 4'b0001, 4'b0000);
    for (int i = 0; i < 8; i++) add(4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 7; i++) add(4'b0000, (i >= 6) ? 4'b0000 : 4'b0001, 4'b0000);
    // all four together, then released together
    for (int i = 0; i < 8; i++) add(4'b1111, (i >= 6) ? 4'b1111 : 4'b0000, (i == 6) ? 4'b1111 : 4'b0000);
    for (int i = 0; i < 7; i++) add(4'b0000, (i >= 6) ? 4'b0000 : 4'b1111, 4'b0000);

    rst        = 1'b1;
    bus.btn_in = 4'b0000;
    #23;
    check("reset_lvl", levels(), 4'b0000);
    check("reset_pls", bus.btn_pulse, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000);
    check("post_reset_lvl", levels(), 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].btn);
      check($sformatf("vec%0d_lvl", i), levels(), tbl[i].lvl);
      if (!AR) check($sformatf("vec%0d_pls", i), bus.btn_pulse, tbl[i].pls);
    end

    // Reset while up is HELD: outputs clear without a clock edge
    for (int i = 0; i < 8; i++) step(4'b1000);
    check("pre_rst_held", levels(), 4'b1000);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_lvl", levels(), 4'b0000);
    check("async_rst_pls", bus.btn_pulse, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Still held after reset: full debounce again and a fresh strobe
    for (int i = 0; i < 7; i++) begin
      step(4'b1000);
      check($sformatf("rehold%0d_lvl", i), levels(), (i >= 6) ? 4'b1000 : 4'b0000);
      check($sformatf("rehold%0d_pls", i), bus.btn_pulse, (i == 6) ? 4'b1000 : 4'b0000);
    end

    // Long hold: no extra strobes without auto-repeat; repeat cadence with it
    for (int k = 1; k <= 30; k++) begin
      step(4'b1000);
      check($sformatf("hold%0d_lvl", k), levels(), 4'b1000);
      check($sformatf("hold%0d_pls", k), bus.btn_pulse,
            (AR && k >= 8 && ((k - 8) % 4) == 0) ? 4'b1000 : 4'b0000);
    end
    for (int i = 0; i < 7; i++) begin
      int k = 31 + i;
      step(4'b0000);
      check($sformatf("rel%0d_lvl", i), levels(), (i >= 6) ? 4'b0000 : 4'b1000);
      check($sformatf("rel%0d_pls", i), bus.btn_pulse,
            (AR && i < 6 && ((k - 8) % 4) == 0) ? 4'b1000 : 4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      step(4'b0000);
      check($sformatf("idle%0d_pls", i), bus.btn_pulse, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
